// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: pointer, flag and strobe logic for a FIFO built around an
// external single-clock RAM with one cycle of read latency. The requester
// drives write data straight into the RAM. This block hands out addresses,
// tracks occupancy and exports Gray-coded pointers for a synchronizer.
module ram_fifo_ctrl #(
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  wr_err,
  output logic                  rd_err
);

  localparam logic [ADDR_WIDTH:0] AFULL_LVL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] wr_ptr_nxt;
  logic [ADDR_WIDTH:0] rd_ptr_nxt;
  logic [ADDR_WIDTH:0] level_nxt;
  logic                wr_accept;
  logic                rd_accept;
  logic                full_nxt;
  logic                empty_nxt;

  // Accept decisions use the registered flags. Reset masks both so the RAM
  // never sees a strobe while the controller is being cleared.
  always_comb begin
    wr_accept  = wr_en & ~full  & rst_n;
    rd_accept  = rd_en & ~empty & rst_n;
    wr_ptr_nxt = wr_ptr + {{ADDR_WIDTH{1'b0}}, wr_accept};
    rd_ptr_nxt = rd_ptr + {{ADDR_WIDTH{1'b0}}, rd_accept};
    level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
    full_nxt   = (wr_ptr_nxt[ADDR_WIDTH] != rd_ptr_nxt[ADDR_WIDTH]) &&
                 (wr_ptr_nxt[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]);
  end

  assign ram_wr_en   = wr_accept;
  assign ram_rd_en   = rd_accept;
  assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

  // Register the pointers and everything derived from the post-edge pointer values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      wr_ptr_gray  <= '0;
      rd_ptr_gray  <= '0;
      rd_valid     <= 1'b0;
      wr_err       <= 1'b0;
      rd_err       <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      level        <= level_nxt;
      empty        <= empty_nxt;
      full         <= full_nxt;
      almost_full  <= (level_nxt >= AFULL_LVL);
      almost_empty <= (level_nxt <= AEMPTY_LVL);
      wr_ptr_gray  <= wr_ptr_nxt ^ (wr_ptr_nxt >> 1);
      rd_ptr_gray  <= rd_ptr_nxt ^ (rd_ptr_nxt >> 1);
      rd_valid     <= rd_accept;
      wr_err       <= wr_en & full;
      rd_err       <= rd_en & empty;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: directed bench for ram_fifo_ctrl at the default sizes
// (depth 16, almost_full at 12, almost_empty at 2).
module tb_ram_fifo_ctrl;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic       rd_en;
  logic       ram_wr_en;
  logic [3:0] ram_wr_addr;
  logic       ram_rd_en;
  logic [3:0] ram_rd_addr;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] level;
  logic [4:0] wr_ptr_gray;
  logic [4:0] rd_ptr_gray;
  logic       wr_err;
  logic       rd_err;

  int errorCount = 0;
  int checkCount = 0;

  ram_fifo_ctrl #(.ADDR_WIDTH(4), .AFULL_THRESH(12), .AEMPTY_THRESH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_rd_en    (ram_rd_en),
    .ram_rd_addr  (ram_rd_addr),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .wr_ptr_gray  (wr_ptr_gray),
    .rd_ptr_gray  (rd_ptr_gray),
    .wr_err       (wr_err),
    .rd_err       (rd_err)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Gray code of a 5-bit pointer value.
  function automatic int grayOf(input int b);
    int v;
    v = b & 31;
    return (v ^ (v >> 1)) & 31;
  endfunction

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input int got, input int exp);
    checkCount++;
    if (got != exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive inputs on the falling edge so combinational outputs settle before the check.
  task automatic applyStimulus(input logic rst, input logic w, input logic r);
    @(negedge clk);
    rst_n = rst;
    wr_en = w;
    rd_en = r;
    #1;
  endtask

  // Advance past the next rising edge to observe registered outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int prevGray;
  int wrp;
  int rdp;

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;

    // Reset with both requests active: strobes must stay low.
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("rst_ram_wr_en", ram_wr_en, 0);
    checkOutput("rst_ram_rd_en", ram_rd_en, 0);
    tick();
    checkOutput("rst_level", level, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_aempty", almost_empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_afull", almost_full, 0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_wr_err", wr_err, 0);
    checkOutput("rst_rd_err", rd_err, 0);
    checkOutput("rst_wgray", wr_ptr_gray, 0);
    checkOutput("rst_rgray", rd_ptr_gray, 0);

    // Fill with 16 writes.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("fill_ram_wr_en", ram_wr_en, 1);
      checkOutput("fill_wr_addr", ram_wr_addr, i);
      tick();
      checkOutput("fill_level", level, i + 1);
      checkOutput("fill_afull", almost_full, (i + 1 >= 12) ? 1 : 0);
      checkOutput("fill_full", full, (i == 15) ? 1 : 0);
      checkOutput("fill_empty", empty, 0);
      checkOutput("fill_wgray", wr_ptr_gray, grayOf(i + 1));
    end

    // Write into a full FIFO is rejected.
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("ovf_ram_wr_en", ram_wr_en, 0);
    tick();
    checkOutput("ovf_wr_err", wr_err, 1);
    checkOutput("ovf_level", level, 16);
    checkOutput("ovf_full", full, 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("ovf_wr_err_pulse", wr_err, 0);

    // Drain with 16 reads.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("drain_ram_rd_en", ram_rd_en, 1);
      checkOutput("drain_rd_addr", ram_rd_addr, i);
      tick();
      checkOutput("drain_rd_valid", rd_valid, 1);
      checkOutput("drain_level", level, 15 - i);
      checkOutput("drain_empty", empty, (i == 15) ? 1 : 0);
      checkOutput("drain_aempty", almost_empty, (15 - i <= 2) ? 1 : 0);
      checkOutput("drain_full", full, 0);
    end

    // Read from an empty FIFO is rejected.
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("udf_ram_rd_en", ram_rd_en, 0);
    tick();
    checkOutput("udf_rd_err", rd_err, 1);
    checkOutput("udf_rd_valid", rd_valid, 0);
    checkOutput("udf_level", level, 0);

    // Empty with both requests: only the write goes through.
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("eboth_ram_wr_en", ram_wr_en, 1);
    checkOutput("eboth_ram_rd_en", ram_rd_en, 0);
    tick();
    checkOutput("eboth_level", level, 1);
    checkOutput("eboth_rd_err", rd_err, 1);
    checkOutput("eboth_empty", empty, 0);

    // Four more writes take the level to 5 (wr_ptr 21, rd_ptr 16).
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      tick();
    end
    checkOutput("lvl5_level", level, 5);

    // Forty cycles of simultaneous write and read, wrapping both pointers.
    wrp = 21;
    rdp = 16;
    prevGray = wr_ptr_gray;
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("both_wr_addr", ram_wr_addr, wrp % 16);
      checkOutput("both_rd_addr", ram_rd_addr, rdp % 16);
      tick();
      wrp = (wrp + 1) % 32;
      rdp = (rdp + 1) % 32;
      checkOutput("both_level", level, 5);
      checkOutput("both_wgray", wr_ptr_gray, grayOf(wrp));
      checkOutput("both_rgray", rd_ptr_gray, grayOf(rdp));
      checkOutput("both_gray_1bit", $countones(5'(prevGray) ^ wr_ptr_gray), 1);
      prevGray = wr_ptr_gray;
    end

    // Refill with 11 writes to full, then present both requests.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      tick();
    end
    checkOutput("refill_full", full, 1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("fboth_ram_wr_en", ram_wr_en, 0);
    checkOutput("fboth_ram_rd_en", ram_rd_en, 1);
    tick();
    checkOutput("fboth_level", level, 15);
    checkOutput("fboth_wr_err", wr_err, 1);
    checkOutput("fboth_full", full, 0);
    checkOutput("fboth_rd_valid", rd_valid, 1);

    // Read down to level 9 so a read is in flight, then pulse reset.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      tick();
    end
    checkOutput("pre_rst_level", level, 9);
    checkOutput("pre_rst_rd_valid", rd_valid, 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("mid_rst_ram_rd_en", ram_rd_en, 0);
    tick();
    checkOutput("mid_rst_rd_valid", rd_valid, 0);
    checkOutput("mid_rst_level", level, 0);
    checkOutput("mid_rst_empty", empty, 1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("post_rst_wr_addr", ram_wr_addr, 0);
    checkOutput("post_rst_ram_wr_en", ram_wr_en, 1);
    tick();
    checkOutput("post_rst_level", level, 1);
    checkOutput("post_rst_rd_valid", rd_valid, 0);

    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, sets RAM address width; FIFO depth is 2**ADDR_WIDTH entries.
REQ-002 Parameter AFULL_THRESH, default 12, sets the level at or above which almost_full asserts.
REQ-003 Parameter AEMPTY_THRESH, default 2, sets the level at or below which almost_empty asserts.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 wr_en  input  1  write request; data is presented to the RAM by the requester.
REQ-007 rd_en  input  1  read request.
REQ-008 ram_wr_en  output  1  RAM write strobe.
REQ-009 ram_wr_addr  output  ADDR_WIDTH  RAM write address.
REQ-010 ram_rd_en  output  1  RAM read strobe (RAM has 1-cycle read latency).
REQ-011 ram_rd_addr  output  ADDR_WIDTH  RAM read address.
REQ-012 rd_valid  output  1  RAM read data valid this cycle.
REQ-013 full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 level  output  ADDR_WIDTH+1  occupied entries, 0..2**ADDR_WIDTH.
REQ-015 wr_ptr_gray, rd_ptr_gray  output  ADDR_WIDTH+1 each  Gray-coded pointers for clock-domain export.
REQ-016 wr_err, rd_err  output  1 each  one-cycle pulse on rejected write/read.

Function
REQ-017 Internal wr_ptr, rd_ptr: ADDR_WIDTH+1-bit binary; increment by 1 per accepted op; wrap 2**(ADDR_WIDTH+1)-1 -> 0 modulo arithmetic.
REQ-018 wr_accept = wr_en & ~full; rd_accept = rd_en & ~empty; both evaluated on registered flags of the current cycle.
REQ-019 ram_wr_en = wr_accept, ram_rd_en = rd_accept, combinational same cycle; ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0], ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0].
REQ-020 rd_valid registered: asserts exactly one cycle after rd_accept, for one cycle per accepted read.
REQ-021 level = wr_ptr - rd_ptr (ADDR_WIDTH+1 bits); registered, reflects post-edge pointers.
REQ-022 empty = (next wr_ptr == next rd_ptr); full = MSBs differ and lower ADDR_WIDTH bits equal; both registered from next-pointer values so flags are valid the cycle after the access.
REQ-023 almost_full = (level >= AFULL_THRESH); almost_empty = (level <= AEMPTY_THRESH); registered, same timing as full/empty.
REQ-024 Gray outputs registered: gray = bin ^ (bin >> 1) of the post-edge pointer; exactly one bit changes per increment, including wrap.
REQ-025 Simultaneous accepted write and read: both pointers advance, level and flags unchanged.
REQ-026 When full with wr_en and rd_en: read accepted, write rejected (wr_err pulses); full deasserts next cycle.
REQ-027 When empty with wr_en and rd_en: write accepted, read rejected (rd_err pulses); empty deasserts next cycle.
REQ-028 Rejected ops never move pointers, never assert RAM strobes; wr_err/rd_err registered, one cycle after the rejected request.

Reset
REQ-029 On clk edge with rst_n=0: wr_ptr=rd_ptr=0, level=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, wr_err=rd_err=0, gray pointers=0.
REQ-030 During reset ram_wr_en and ram_rd_en are forced 0 regardless of wr_en/rd_en.
REQ-031 Reset mid-operation discards all content and any pending rd_valid; first cycle after rst_n=1 behaves as post-reset idle.

Verification (ADDR_WIDTH=4, defaults)
REQ-032 Reset, then 16 consecutive writes -> ram_wr_addr 0..15, level 16, full=1 one cycle after 16th write, almost_full from level 12.
REQ-033 When full, 17th write -> no ram_wr_en, wr_err pulse next cycle, level stays 16.
REQ-034 Drain 16 reads -> ram_rd_addr 0..15, rd_valid each following cycle, empty=1 after last, then rd_en -> rd_err, no ram_rd_en.
REQ-035 Level 5, wr_en&rd_en for 40 cycles -> level stays 5, pointers wrap past 31 to 0, each wr_ptr_gray step changes exactly one bit (31->0: 10000->00000).
REQ-036 Full + simultaneous wr_en/rd_en -> read only, level 15, wr_err=1; empty + both -> write only, level 1, rd_err=1.
REQ-037 rst_n=0 for one cycle at level 9 with a read just accepted -> rd_valid=0 next cycle, level 0, empty=1.
